// File: rtl/pm_sync_gen.sv
// Single-cycle sync_awg pulse generator for the PM pattern player (one-shot, triggered burst, continuous).
// Optional ext_trig glitch filter enabled by defining PM_SYNC_TRIG_FILTER_EN.
module pm_sync_gen #(
   parameter int PERIOD_W   = 32,
   parameter int DELAY_W    = 16,
   parameter int CNT_W      = 16,
   parameter int MIN_GAP    = 8,
   parameter int FILTER_LEN = 4
) (
   input  logic                clk_adc,
   input  logic                rst_adc_n,
   input  logic [1:0]          cfg_mode,
   input  logic [PERIOD_W-1:0] cfg_period,
   input  logic [DELAY_W-1:0]  cfg_delay,
   input  logic [CNT_W-1:0]    cfg_burst,
   input  logic                cfg_arm,
   input  logic                cfg_abort,
   input  logic                ext_trig,
   output logic                sync_awg,
   output logic                busy,
   output logic                armed,
   output logic [CNT_W-1:0]    pulse_cnt
);

   localparam int CW = (PERIOD_W > DELAY_W) ? PERIOD_W : DELAY_W;

   if (MIN_GAP < 2 || FILTER_LEN < 1) begin : g_bad_param
      $error("pm_sync_gen: MIN_GAP must be >= 2 and FILTER_LEN >= 1");
   end

   typedef enum logic [2:0] {IDLE, WAIT_TRIG, DELAY, FIRE, GAP} state_t;

   state_t              state;
   logic [CW-1:0]       cnt;
   logic [1:0]          mode_q;
   logic [PERIOD_W-1:0] gap_ld;
   logic [CNT_W-1:0]    burst_q;
   logic [PERIOD_W-1:0] per_eff;
   logic [CNT_W-1:0]    cnt_inc;
   logic                trig_s1, trig_s2, trig_lvl, trig_lvl_d, trig_rise;

   assign per_eff = (cfg_period < PERIOD_W'(MIN_GAP)) ? PERIOD_W'(MIN_GAP) : cfg_period;
   assign cnt_inc = (&pulse_cnt) ? pulse_cnt : pulse_cnt + 1'b1;

   always_ff @(posedge clk_adc or negedge rst_adc_n) begin
      if (!rst_adc_n) begin
         trig_s1 <= 1'b0;
         trig_s2 <= 1'b0;
      end else begin
         trig_s1 <= ext_trig;
         trig_s2 <= trig_s1;
      end
   end

`ifdef PM_SYNC_TRIG_FILTER_EN
   localparam int FW = $clog2(FILTER_LEN + 1);
   logic [FW-1:0] flt_cnt;

   // Level qualifies only after FILTER_LEN consecutive high samples; any low restarts.
   always_ff @(posedge clk_adc or negedge rst_adc_n) begin
      if (!rst_adc_n)                      flt_cnt <= '0;
      else if (!trig_s2)                   flt_cnt <= '0;
      else if (flt_cnt != FW'(FILTER_LEN)) flt_cnt <= flt_cnt + 1'b1;
   end
   assign trig_lvl = (flt_cnt == FW'(FILTER_LEN));
`else
   assign trig_lvl = trig_s2;
`endif

   always_ff @(posedge clk_adc or negedge rst_adc_n) begin
      if (!rst_adc_n) begin
         trig_lvl_d <= 1'b0;
         trig_rise  <= 1'b0;
      end else begin
         trig_lvl_d <= trig_lvl;
         trig_rise  <= trig_lvl & ~trig_lvl_d;
      end
   end

   always_ff @(posedge clk_adc or negedge rst_adc_n) begin
      if (!rst_adc_n) begin
         state     <= IDLE;
         cnt       <= '0;
         mode_q    <= '0;
         gap_ld    <= '0;
         burst_q   <= '0;
         pulse_cnt <= '0;
         sync_awg  <= 1'b0;
         busy      <= 1'b0;
         armed     <= 1'b0;
      end else begin
         sync_awg <= 1'b0;
         if (cfg_abort) begin
            state <= IDLE;
            busy  <= 1'b0;
            armed <= 1'b0;
         end else begin
            unique case (state)
               IDLE: if (cfg_arm) begin
                  mode_q    <= cfg_mode;
                  gap_ld    <= per_eff - PERIOD_W'(2);
                  burst_q   <= (cfg_burst == '0) ? CNT_W'(1) : cfg_burst;
                  pulse_cnt <= '0;
                  cnt       <= CW'(cfg_delay);
                  busy      <= 1'b1;
                  if (cfg_mode == 2'd1) begin
                     state <= WAIT_TRIG;
                     armed <= 1'b1;
                  end else begin
                     state <= DELAY;
                  end
               end
               // cnt already holds the latched delay while waiting
               WAIT_TRIG: if (trig_rise) begin
                  state <= DELAY;
                  armed <= 1'b0;
               end
               DELAY, GAP: begin
                  if (cnt == '0) begin
                     state     <= FIRE;
                     sync_awg  <= 1'b1;
                     pulse_cnt <= cnt_inc;
                  end else begin
                     cnt <= cnt - 1'b1;
                  end
               end
               // pulse_cnt already counts the pulse being issued this cycle
               FIRE: begin
                  if (mode_q == 2'd2 || (mode_q == 2'd1 && pulse_cnt < burst_q)) begin
                     state <= GAP;
                     cnt   <= CW'(gap_ld);
                  end else begin
                     state <= IDLE;
                     busy  <= 1'b0;
                  end
               end
               default: begin
                  state <= IDLE;
                  busy  <= 1'b0;
                  armed <= 1'b0;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_pm_sync_gen.sv
// Scoreboard bench for pm_sync_gen: expected pulse cycles are queued from a timing model, a monitor pops them.
module tb_pm_sync_gen;
   localparam int PERIOD_W = 32, DELAY_W = 16, CNT_W = 16, MIN_GAP = 8, FILTER_LEN = 4;
`ifdef PM_SYNC_TRIG_FILTER_EN
   localparam int TRIG_LAT = 3 + FILTER_LEN;
`else
   localparam int TRIG_LAT = 3;
`endif

   logic                clk_adc = 1'b0;
   logic                rst_adc_n = 1'b0;
   logic [1:0]          cfg_mode = '0;
   logic [PERIOD_W-1:0] cfg_period = '0;
   logic [DELAY_W-1:0]  cfg_delay = '0;
   logic [CNT_W-1:0]    cfg_burst = '0;
   logic                cfg_arm = 1'b0;
   logic                cfg_abort = 1'b0;
   logic                ext_trig = 1'b0;
   logic                sync_awg, busy, armed;
   logic [CNT_W-1:0]    pulse_cnt;

   int cyc = 0;
   int total = 0;
   int bad = 0;
   int exp_q[$];

   pm_sync_gen #(.PERIOD_W(PERIOD_W), .DELAY_W(DELAY_W), .CNT_W(CNT_W),
                 .MIN_GAP(MIN_GAP), .FILTER_LEN(FILTER_LEN)) dut (
      .clk_adc(clk_adc), .rst_adc_n(rst_adc_n), .cfg_mode(cfg_mode), .cfg_period(cfg_period),
      .cfg_delay(cfg_delay), .cfg_burst(cfg_burst), .cfg_arm(cfg_arm), .cfg_abort(cfg_abort),
      .ext_trig(ext_trig), .sync_awg(sync_awg), .busy(busy), .armed(armed), .pulse_cnt(pulse_cnt));

   always #5 clk_adc = ~clk_adc;
   always @(posedge clk_adc) cyc <= cyc + 1;

   task automatic chk(input string nm, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   // Monitor: every observed pulse must match the oldest expected pulse cycle.
   always @(negedge clk_adc) begin
      if (rst_adc_n && sync_awg) begin
         if (exp_q.size() == 0) chk("unexpected sync_awg", cyc, 0);
         else                   chk("sync_awg cycle", cyc, exp_q.pop_front());
      end
   end

   // Reference model: DELAY entered at edge start -> pulses at start+1+dly+i*max(per,MIN_GAP).
   function automatic int expect_pulses(input int start, input int dly, input int per, input int n);
      int p = (per < MIN_GAP) ? MIN_GAP : per;
      for (int i = 0; i < n; i++) exp_q.push_back(start + 1 + dly + i * p);
      return start + 1 + dly + (n - 1) * p;
   endfunction

   task automatic tick(input int n);
      repeat (n) @(negedge clk_adc);
   endtask

   task automatic wait_until(input int c);
      while (cyc < c) @(negedge clk_adc);
   endtask

   task automatic arm(input int m, input int per, input int dly, input int bst, output int k);
      cfg_mode = 2'(m); cfg_period = PERIOD_W'(per); cfg_delay = DELAY_W'(dly);
      cfg_burst = CNT_W'(bst); cfg_arm = 1'b1;
      k = cyc + 1;
      @(negedge clk_adc);
      cfg_arm = 1'b0;
      cfg_mode = 2'($urandom); cfg_period = PERIOD_W'($urandom_range(0, 3));
      cfg_delay = DELAY_W'($urandom); cfg_burst = CNT_W'($urandom);
   endtask

   task automatic run_oneshot(input int m, input int dly);
      int k, t;
      arm(m, $urandom_range(0, 40), dly, $urandom_range(0, 9), k);
      t = expect_pulses(k, dly, 0, 1);
      wait_until(t);
      chk("oneshot busy at pulse", int'(busy), 1);
      tick(1);
      chk("oneshot busy after", int'(busy), 0);
      chk("oneshot pulse_cnt", int'(pulse_cnt), 1);
      chk("oneshot missing pulse", exp_q.size(), 0);
   endtask

   task automatic run_burst(input int per, input int dly, input int bst, input int hi_len);
      int k, a, last, n;
      n = (bst == 0) ? 1 : bst;
      arm(1, per, dly, bst, k);
      tick($urandom_range(2, 5));
      chk("burst armed before trig", int'(armed), 1);
      ext_trig = 1'b1;
      a = cyc + 1;
      last = expect_pulses(a + TRIG_LAT, dly, per, n);
      for (int i = 1; i <= TRIG_LAT + 1; i++) begin
         @(negedge clk_adc);
         if (cyc == a - 1 + hi_len) ext_trig = 1'b0;
         if (i == TRIG_LAT)     chk("armed until trig", int'(armed), 1);
         if (i == TRIG_LAT + 1) chk("armed cleared by trig", int'(armed), 0);
      end
      wait_until(a - 1 + hi_len);
      ext_trig = 1'b0;
      tick(3);
      ext_trig = 1'b1;
      tick(2);
      ext_trig = 1'b0;
      wait_until(((last + 2) > (a + hi_len + 15)) ? last + 2 : a + hi_len + 15);
      chk("burst busy after", int'(busy), 0);
      chk("burst pulse_cnt", int'(pulse_cnt), n);
      chk("burst missing pulses", exp_q.size(), 0);
   endtask

   initial begin
      #500000;
      $display("FAIL timeout: simulation did not finish (cycle %0d)", cyc);
      $fatal(1);
   end

   initial begin
      int k, t5, ab;
      tick(3);
      chk("reset sync_awg", int'(sync_awg), 0);
      chk("reset busy", int'(busy), 0);
      chk("reset armed", int'(armed), 0);
      chk("reset pulse_cnt", int'(pulse_cnt), 0);
      rst_adc_n = 1'b1;
      tick(2);

      // Reset during a continuous run, then stay idle
      arm(2, 10, 2, 0, k);
      void'(expect_pulses(k, 2, 10, 2));
      wait_until(k + 15);
      rst_adc_n = 1'b0;
      tick(2);
      rst_adc_n = 1'b1;
      for (int i = 0; i < 10; i++) begin
         tick(10);
         chk("idle busy", int'(busy), 0);
         chk("idle pulse_cnt", int'(pulse_cnt), 0);
      end
      chk("idle missing pulses", exp_q.size(), 0);

      // One-shot: fixed delay 5, then randomized (mode 3 behaves as 0)
      run_oneshot(0, 5);
      for (int i = 0; i < 4; i++) run_oneshot((i % 2 == 0) ? 0 : 3, $urandom_range(0, 15));

      // External-trigger bursts
      run_burst(20, 0, 3, 10);
      for (int i = 0; i < 3; i++)
         run_burst($urandom_range(0, 30), $urandom_range(0, 8), $urandom_range(0, 4),
                   $urandom_range(6, 12));

      // Continuous with clamped period, stray arm, abort after the 5th pulse
      arm(2, 3, $urandom_range(0, 5), 0, k);
      t5 = expect_pulses(k, int'(dut.cnt), 3, 5);
      tick(10);
      cfg_mode = 2'd0; cfg_delay = '0; cfg_arm = 1'b1;
      tick(1);
      cfg_arm = 1'b0;
      ab = t5 + $urandom_range(1, MIN_GAP - 1);
      wait_until(ab - 1);
      chk("cont busy before abort", int'(busy), 1);
      cfg_abort = 1'b1;
      tick(1);
      cfg_abort = 1'b0;
      chk("abort busy", int'(busy), 0);
      tick(30);
      chk("abort pulse_cnt held", int'(pulse_cnt), 5);
      chk("cont missing pulses", exp_q.size(), 0);

      // Arm and abort together while idle
      cfg_mode = 2'd0; cfg_delay = '0; cfg_arm = 1'b1; cfg_abort = 1'b1;
      tick(1);
      cfg_arm = 1'b0; cfg_abort = 1'b0;
      chk("collision busy", int'(busy), 0);
      tick(10);
      chk("collision pulse_cnt", int'(pulse_cnt), 5);

      // Reset mid-DELAY: nothing may fire afterwards
      arm(0, 0, 20, 0, k);
      tick(5);
      chk("delay busy", int'(busy), 1);
      rst_adc_n = 1'b0;
      tick(1);
      chk("mid reset busy", int'(busy), 0);
      chk("mid reset pulse_cnt", int'(pulse_cnt), 0);
      rst_adc_n = 1'b1;
      tick(40);
      chk("post reset busy", int'(busy), 0);

`ifdef PM_SYNC_TRIG_FILTER_EN
      // Short trigger pulse must be rejected by the filter
      arm(1, 20, 0, 2, k);
      tick(3);
      ext_trig = 1'b1;
      tick(3);
      ext_trig = 1'b0;
      tick(15);
      chk("filter short pulse armed", int'(armed), 1);
      cfg_abort = 1'b1;
      tick(1);
      cfg_abort = 1'b0;
      chk("filter abort armed", int'(armed), 0);
      run_burst(20, 0, 3, 6);
`endif

      chk("final missing pulses", exp_q.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/pm_sync_gen.md
Name: pm_sync_gen

Overview:
- Generates the single-cycle sync_awg pulse, in the clk_adc domain, that restarts the PM pattern readout.
- Sits directly upstream of the PM pattern player, whose sync_awg input crosses to fast_c through a pulse CDC.
- Supports three modes: software one-shot, externally triggered burst, and continuous periodic.
- Enforces a minimum pulse spacing so that no pulse is lost in the downstream pulse CDC.

Parameters:
PERIOD_W, 32, width of cfg_period and of the period counter
DELAY_W, 16, width of cfg_delay and of the delay counter
CNT_W, 16, width of cfg_burst and of pulse_cnt
MIN_GAP, 8, minimum cycles between sync_awg pulses; must be >= 2
FILTER_LEN, 4, ext_trig glitch-filter length; used only with the optional feature

Ports:
clk_adc  in  1  block clock
rst_adc_n  in  1  reset, asynchronous assert, active-low
cfg_mode  in  2  0=one-shot, 1=ext-trigger burst, 2=continuous, 3=reserved (behaves as 0)
cfg_period  in  PERIOD_W  cycles from one pulse to the next
cfg_delay  in  DELAY_W  cycles from start event to first pulse
cfg_burst  in  CNT_W  pulses per burst in mode 1; 0 behaves as 1
cfg_arm  in  1  single-cycle start request
cfg_abort  in  1  single-cycle stop request
ext_trig  in  1  asynchronous external trigger, level input
sync_awg  out  1  registered single-cycle sync pulse
busy  out  1  high whenever state != IDLE
armed  out  1  high in WAIT_TRIG
pulse_cnt  out  CNT_W  pulses issued since last arm; saturates at all-ones

Behaviour:
- Reset (async, rst_adc_n=0):
  - state=IDLE, all counters 0.
  - sync_awg=0, busy=0, armed=0, pulse_cnt=0.
  - ext_trig synchronizer flops cleared.
- ext_trig: 2-FF synchronizer, then a registered rising-edge detect (trig_rise). trig_rise is usable 3 edges after the first edge sampling ext_trig=1.
- Config latching: cfg_mode, cfg_period, cfg_delay and cfg_burst are latched on the edge that accepts cfg_arm. Later config changes have no effect until the next arm.
- Effective period P = max(cfg_period, MIN_GAP).
- IDLE:
  - cfg_arm=1: pulse_cnt<=0.
  - Mode 1 -> WAIT_TRIG; otherwise -> DELAY with delay counter=cfg_delay.
- WAIT_TRIG: trig_rise -> DELAY. Triggers arriving in any other state are ignored.
- DELAY:
  - Counter decrements each cycle; at 0 -> FIRE.
  - Arm accepted at edge k: sync_awg is high in the cycle after edge k+1+cfg_delay.
  - cfg_delay=0 gives a 1-cycle latency to FIRE entry.
- FIRE (1 cycle):
  - sync_awg=1 this cycle only; pulse_cnt increments.
  - Mode 0 -> IDLE.
  - Mode 1: pulses issued equals cfg_burst -> IDLE; otherwise -> GAP.
  - Mode 2 -> GAP.
- GAP: counter loaded with P-2; -> FIRE when it reaches 0. Consecutive pulses are exactly P cycles apart.
- cfg_abort:
  - Any state -> IDLE on the next edge.
  - Abort has priority over arm, trigger and FIRE.
  - A pulse in flight on the abort edge completes. No further pulse occurs.
  - pulse_cnt is held, not cleared.
- cfg_arm while busy: ignored.
- cfg_arm and cfg_abort in the same cycle while IDLE: abort wins, stay IDLE.
- Mode 2 never self-terminates; only abort or reset stops it.
- Reset mid-burst: immediate IDLE, and no pulse is emitted after deassertion.
- Counter arithmetic: unsigned; no wrap in DELAY or GAP. pulse_cnt saturates.

Optional Feature:
- Macro PM_SYNC_TRIG_FILTER_EN.
- Defined:
  - After the synchronizer, the trigger level must be stable high for FILTER_LEN consecutive cycles before trig_rise asserts.
  - Any low sample resets the filter.
  - Trigger latency grows by FILTER_LEN cycles.
  - Pulses shorter than FILTER_LEN cycles are rejected.
- Undefined: no filter; trig_rise follows the synchronizer directly.

Test Plan:
- Reset then idle: rst_adc_n low mid-run, then release; hold inputs idle 100 cycles -> sync_awg=0, busy=0, pulse_cnt=0 throughout.
- One-shot: mode 0, delay 5, arm at edge k -> exactly one sync_awg pulse, in the cycle after edge k+6; pulse_cnt=1; busy drops the following cycle.
- External burst: mode 1, delay 0, period 20, burst 3; ext_trig high 10 cycles -> 3 pulses spaced 20 cycles apart; first pulse 4 cycles after the first high sample; armed high until the trigger; extra trigger edges ignored.
- Period clamp and continuous:
  - Mode 2, period 3 -> pulses every MIN_GAP=8 cycles.
  - Abort after the 5th pulse -> no 6th pulse; pulse_cnt=5; cfg_arm during the run ignored.
- Arm/abort collision and mid-run reset: arm and abort in the same cycle -> stays IDLE; reset asserted mid-DELAY -> no pulse.
- With PM_SYNC_TRIG_FILTER_EN (FILTER_LEN=4): ext_trig high 3 cycles -> no pulse; high 6 cycles -> one burst, first pulse 4 cycles later than in the unfiltered build.
